sdram_write_port: RTL and testbench

Host-to-SDRAM write engine for the 640x480 framebuffer; the write direction complementing the VGA line reader. Host writes are accepted into a small FIFO. When the arbiter grants the SDRAM bus, they are drained as single-word WRITE commands, one open row per transaction. It drives the same SDRAM command pins and relies on the mode register set at init: CAS=2, single-location write burst. The top-level mux selects between this block and the reader.

---
 rtl/sdram_pkg.sv | 52 +++++
 rtl/sdram_wfifo.sv | 91 +++++++++
 rtl/sdram_write_port.sv | 226 ++++++++++++++++++++++
 tb/tb_sdram_write_port.sv | 514 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// -----------------------------------------------------------------------------
// sdram_pkg
// Shared definitions for the SDRAM framebuffer write port:
//   - SDRAM command codes driven on {ras, cas, we}
//   - bit positions of the bank/row/column fields in a 22-bit word address
//   - FSM state codes for the write engine
//   - FIFO entry layout {address, be, data} and a row-tag helper
// -----------------------------------------------------------------------------
package sdram_pkg;

  // SDRAM commands as {ras, cas, we}
  localparam logic [2:0] CMD_NOP       = 3'b111;
  localparam logic [2:0] CMD_ACTIVATE  = 3'b011;
  localparam logic [2:0] CMD_WRITE     = 3'b100;
  localparam logic [2:0] CMD_PRECHARGE = 3'b010;
  localparam logic [2:0] CMD_REFRESH   = 3'b001;
  localparam logic [2:0] CMD_LOADMODE  = 3'b000;

  // Word address fields: bank=[21:20], row=[19:8], column=[7:0]
  localparam int ADDR_W   = 22;
  localparam int BANK_MSB = 21;
  localparam int BANK_LSB = 20;
  localparam int ROW_MSB  = 19;
  localparam int ROW_LSB  = 8;
  localparam int COL_MSB  = 7;
  localparam int COL_LSB  = 0;

  // Bank+row tag width, used to decide whether two words share an open row
  localparam int TAG_W = BANK_MSB - ROW_LSB + 1;

  // Write-engine FSM states
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_RCD    = 3'd1;
  localparam state_t ST_WRITE  = 3'd2;
  localparam state_t ST_WR_REC = 3'd3;
  localparam state_t ST_PRE    = 3'd4;
  localparam state_t ST_RP     = 3'd5;

  // One queued host write (40 bits)
  typedef struct packed {
    logic [ADDR_W-1:0] address;
    logic [1:0]        be;
    logic [15:0]       data;
  } wentry_t;

  // Bank and row of a word address; equal tags can share one ACTIVATE
  function automatic logic [TAG_W-1:0] row_tag(input logic [ADDR_W-1:0] a);
    return a[BANK_MSB:ROW_LSB];
  endfunction

endpackage

// File: rtl/sdram_wfifo.sv
// -----------------------------------------------------------------------------
// sdram_wfifo
// DEPTH-entry synchronous FIFO holding queued host writes.
// Ports:
//   clock, reset_n  : clock, asynchronous active-low reset (empties the FIFO)
//   push, din       : write request and entry; ignored while full
//   pop             : remove head entry; ignored while empty
//   head            : entry at the read pointer
//   next_tag        : bank+row of the entry behind the head (valid if count>=2)
//   full, empty     : derived from the registered count only
//   count           : number of stored entries, log2(DEPTH)+1 bits
// -----------------------------------------------------------------------------
module sdram_wfifo
  import sdram_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       push,
  input  wentry_t                    din,
  input  logic                       pop,
  output wentry_t                    head,
  output logic [TAG_W-1:0]           next_tag,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] rd_next_s;
  logic          do_push_s;
  logic          do_pop_s;
  wentry_t       mem_q [DEPTH];

  assign full      = (count_q == (AW+1)'(DEPTH));
  assign empty     = (count_q == (AW+1)'(0));
  assign count     = count_q;
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;
  assign rd_next_s = rd_ptr_q + AW'(1);
  assign head      = mem_q[rd_ptr_q];
  assign next_tag  = row_tag(mem_q[rd_next_s].address);

  // Next pointer and occupancy; pointers wrap naturally since DEPTH is a power of two
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_next_s;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset because count gates every read
  always_ff @(posedge clock) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/sdram_write_port.sv
// -----------------------------------------------------------------------------
// sdram_write_port
// Host-to-SDRAM write engine for the framebuffer. Host words are queued in a
// FIFO; once the arbiter grants the bus they are written as single-word WRITE
// commands, one ACTIVATE/PRECHARGE pair per run of same-bank/same-row words.
// Ports:
//   clock, reset_n           : 100 MHz clock, asynchronous active-low reset
//   wr_valid/wr_ready        : host handshake, word taken when both are high
//   address/data_write/data_be : word address {bank,row,col}, pixel, byte enables
//   grant                    : bus granted by the arbiter
//   busy                     : transaction in progress (high outside IDLE)
//   ras/cas/we, addr, bank   : SDRAM command and address pins (registered)
//   dq_out/dq_oe             : write data and its output enable
//   ldqm/udqm                : byte masks, active high (masked)
// -----------------------------------------------------------------------------
module sdram_write_port
  import sdram_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int TRCD  = 3,
  parameter int TWR   = 2,
  parameter int TRP   = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [21:0] address,
  input  logic [15:0] data_write,
  input  logic [1:0]  data_be,
  input  logic        grant,
  output logic        busy,
  output logic        ras,
  output logic        cas,
  output logic        we,
  output logic [11:0] addr,
  output logic [1:0]  bank,
  output logic [15:0] dq_out,
  output logic        dq_oe,
  output logic        ldqm,
  output logic        udqm
);

  localparam int CW = $clog2(DEPTH) + 1;

  // FIFO interface
  wentry_t          din_s;
  wentry_t          head_s;
  logic [TAG_W-1:0] next_tag_s;
  logic             full_s;
  logic             empty_s;
  logic [CW-1:0]    count_s;
  logic             pop_s;

  // FSM and output registers
  state_t           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [2:0]       cmd_q, cmd_d;
  logic [11:0]      addr_q, addr_d;
  logic [1:0]       bank_q, bank_d;
  logic [15:0]      dq_out_q, dq_out_d;
  logic             dq_oe_q, dq_oe_d;
  logic             ldqm_q, ldqm_d;
  logic             udqm_q, udqm_d;
  logic             busy_q, busy_d;

  assign din_s    = '{address: address, be: data_be, data: data_write};
  assign wr_ready = ~full_s;

  sdram_wfifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset_n  (reset_n),
    .push     (wr_valid),
    .din      (din_s),
    .pop      (pop_s),
    .head     (head_s),
    .next_tag (next_tag_s),
    .full     (full_s),
    .empty    (empty_s),
    .count    (count_s)
  );

  // Next state and next pin values; every pin is a register loaded from here
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tag_d    = tag_q;
    cmd_d    = CMD_NOP;
    addr_d   = addr_q;
    bank_d   = bank_q;
    dq_out_d = dq_out_q;
    dq_oe_d  = 1'b0;
    ldqm_d   = 1'b1;
    udqm_d   = 1'b1;
    busy_d   = busy_q;
    pop_s    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (!empty_s && grant) begin
          cmd_d  = CMD_ACTIVATE;
          addr_d = head_s.address[ROW_MSB:ROW_LSB];
          bank_d = head_s.address[BANK_MSB:BANK_LSB];
          tag_d  = row_tag(head_s.address);
          busy_d = 1'b1;
          cnt_d  = 8'(TRCD - 1);
          if (TRCD > 1) begin
            state_d = ST_RCD;
          end else begin
            state_d = ST_WRITE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      // TRCD-1 NOPs between ACTIVATE and the first WRITE
      ST_RCD: begin
        if (cnt_q == 8'd1) begin
          state_d = ST_WRITE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      // One WRITE per cycle; the decision to continue looks at the entry
      // behind the one being written, so the run ends without a bubble.
      ST_WRITE: begin
        if (!empty_s) begin
          pop_s    = 1'b1;
          cmd_d    = CMD_WRITE;
          addr_d   = {4'b0000, head_s.address[COL_MSB:COL_LSB]};
          bank_d   = tag_q[TAG_W-1 -: 2];
          dq_out_d = head_s.data;
          dq_oe_d  = 1'b1;
          ldqm_d   = ~head_s.be[0];
          udqm_d   = ~head_s.be[1];
          if ((count_s > CW'(1)) && (next_tag_s == tag_q) && grant) begin
            state_d = ST_WRITE;
          end else begin
            state_d = ST_WR_REC;
            cnt_d   = 8'(TWR);
          end
        end else begin
          state_d = ST_WR_REC;
          cnt_d   = 8'(TWR);
        end
      end

      // Write recovery: TWR NOPs with dq released
      ST_WR_REC: begin
        if (cnt_q <= 8'd1) begin
          state_d = ST_PRE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      // PRECHARGE all banks (A10=1)
      ST_PRE: begin
        cmd_d   = CMD_PRECHARGE;
        addr_d  = 12'h400;
        state_d = ST_RP;
        cnt_d   = 8'(TRP);
      end

      // TRP NOPs with busy held, then one more edge to drop busy in IDLE
      ST_RP: begin
        if (cnt_q == 8'd0) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 8'd0;
      tag_q    <= '0;
      cmd_q    <= CMD_NOP;
      addr_q   <= 12'h000;
      bank_q   <= 2'b00;
      dq_out_q <= 16'h0000;
      dq_oe_q  <= 1'b0;
      ldqm_q   <= 1'b1;
      udqm_q   <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tag_q    <= tag_d;
      cmd_q    <= cmd_d;
      addr_q   <= addr_d;
      bank_q   <= bank_d;
      dq_out_q <= dq_out_d;
      dq_oe_q  <= dq_oe_d;
      ldqm_q   <= ldqm_d;
      udqm_q   <= udqm_d;
      busy_q   <= busy_d;
    end
  end

  assign {ras, cas, we} = cmd_q;
  assign addr   = addr_q;
  assign bank   = bank_q;
  assign dq_out = dq_out_q;
  assign dq_oe  = dq_oe_q;
  assign ldqm   = ldqm_q;
  assign udqm   = udqm_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_sdram_write_port.sv
// -----------------------------------------------------------------------------
// tb_sdram_write_port
// Randomised self-checking bench. A monitor logs every non-NOP command; a
// transaction-level model turns the list of queued words into the expected
// command sequence (ACT, WRITE run, PRE) with cycle stamps from the timing
// rules, and each scenario task compares the log against it.
// -----------------------------------------------------------------------------
module tb_sdram_write_port;

  localparam int DEPTH = 16;
  localparam int TRCD  = 3;
  localparam int TWR   = 2;
  localparam int TRP   = 2;

  localparam logic [2:0] C_NOP = 3'b111;
  localparam logic [2:0] C_ACT = 3'b011;
  localparam logic [2:0] C_WR  = 3'b100;
  localparam logic [2:0] C_PRE = 3'b010;

  logic        clock;
  logic        reset_n;
  logic        wr_valid;
  logic        wr_ready;
  logic [21:0] address;
  logic [15:0] data_write;
  logic [1:0]  data_be;
  logic        grant;
  logic        busy;
  logic        ras, cas, we;
  logic [11:0] addr;
  logic [1:0]  bank;
  logic [15:0] dq_out;
  logic        dq_oe;
  logic        ldqm, udqm;

  sdram_write_port #(
    .DEPTH (DEPTH),
    .TRCD  (TRCD),
    .TWR   (TWR),
    .TRP   (TRP)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .address    (address),
    .data_write (data_write),
    .data_be    (data_be),
    .grant      (grant),
    .busy       (busy),
    .ras        (ras),
    .cas        (cas),
    .we         (we),
    .addr       (addr),
    .bank       (bank),
    .dq_out     (dq_out),
    .dq_oe      (dq_oe),
    .ldqm       (ldqm),
    .udqm       (udqm)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Edge counter: after active edge k, cyc == k
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int          t;
    logic [2:0]  cmd;
    logic [11:0] a;
    logic [1:0]  b;
    logic [15:0] dq;
    logic        oe;
    logic        lm;
    logic        um;
  } ev_t;

  typedef struct {
    logic [21:0] a;
    logic [15:0] d;
    logic [1:0]  be;
  } word_t;

  ev_t   log_q[$];
  ev_t   exp_q[$];
  word_t words_q[$];

  // Command monitor, sampled on the falling edge
  always @(negedge clock) begin
    ev_t e;
    if (reset_n && ({ras, cas, we} !== C_NOP)) begin
      e.t = cyc; e.cmd = {ras, cas, we}; e.a = addr; e.b = bank;
      e.dq = dq_out; e.oe = dq_oe; e.lm = ldqm; e.um = udqm;
      log_q.push_back(e);
    end
  end

  function automatic ev_t mk_ev(input int t, input logic [2:0] c, input logic [11:0] a,
                                input logic [1:0] b, input logic [15:0] dq,
                                input logic oe, input logic lm, input logic um);
    ev_t e;
    e.t = t; e.cmd = c; e.a = a; e.b = b; e.dq = dq; e.oe = oe; e.lm = lm; e.um = um;
    return e;
  endfunction

  // Reference model: group queued words into same bank/row runs, each run is
  // ACT at t, WRITEs from t+TRCD, PRE TWR+1 after the last WRITE, and the next
  // ACT TRP+2 after that PRE.
  task automatic model_expect(input int t0);
    int t;
    int i;
    int j;
    int tw;
    exp_q.delete();
    t = t0;
    i = 0;
    while (i < words_q.size()) begin
      exp_q.push_back(mk_ev(t, C_ACT, words_q[i].a[19:8], words_q[i].a[21:20],
                            16'h0000, 1'b0, 1'b1, 1'b1));
      tw = t + TRCD;
      j  = i;
      while (j < words_q.size() && words_q[j].a[21:8] == words_q[i].a[21:8]) begin
        exp_q.push_back(mk_ev(tw, C_WR, {4'h0, words_q[j].a[7:0]}, words_q[i].a[21:20],
                              words_q[j].d, 1'b1, ~words_q[j].be[0], ~words_q[j].be[1]));
        tw++;
        j++;
      end
      exp_q.push_back(mk_ev(tw - 1 + TWR + 1, C_PRE, 12'h400, 2'b00,
                            16'h0000, 1'b0, 1'b1, 1'b1));
      t = tw - 1 + TWR + 1 + TRP + 2;
      i = j;
    end
  endtask

  // Describes the first difference between log and expectation ("" if none)
  function automatic string diff_log();
    ev_t a;
    ev_t e;
    bit  bad;
    if (log_q.size() != exp_q.size())
      return $sformatf("got %0d commands, required %0d", log_q.size(), exp_q.size());
    foreach (exp_q[k]) begin
      a   = log_q[k];
      e   = exp_q[k];
      bad = (a.t != e.t) || (a.cmd !== e.cmd);
      if (e.cmd == C_WR)
        bad = bad || (a.a !== e.a) || (a.b !== e.b) || (a.dq !== e.dq) ||
              (a.oe !== 1'b1) || (a.lm !== e.lm) || (a.um !== e.um);
      else if (e.cmd == C_ACT)
        bad = bad || (a.a !== e.a) || (a.b !== e.b);
      else
        bad = bad || (a.a[10] !== 1'b1);
      if (bad)
        return $sformatf("cmd %0d got t=%0d cmd=%b a=%h b=%0d dq=%h oe=%b lm=%b um=%b, required t=%0d cmd=%b a=%h b=%0d dq=%h lm=%b um=%b",
                         k, a.t, a.cmd, a.a, a.b, a.dq, a.oe, a.lm, a.um,
                         e.t, e.cmd, e.a, e.b, e.dq, e.lm, e.um);
    end
    return "";
  endfunction

  // Push one word; starts and returns on a falling edge
  task automatic push_word(input logic [21:0] a, input logic [15:0] d, input logic [1:0] be);
    word_t w;
    int    guard;
    guard      = 0;
    wr_valid   = 1'b1;
    address    = a;
    data_write = d;
    data_be    = be;
    while (!wr_ready && guard < 64) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 64) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: wr_ready stayed 0, required 1");
    end
    @(posedge clock);
    #1;
    wr_valid = 1'b0;
    w.a = a; w.d = d; w.be = be;
    words_q.push_back(w);
    @(negedge clock);
  endtask

  // Wait until the expected number of commands is logged (bounded), plus a tail
  task automatic wait_events(input int budget);
    for (int k = 0; k < budget; k++) begin
      @(negedge clock);
      if (log_q.size() >= exp_q.size()) break;
    end
    repeat (TWR + TRP + 10) @(negedge clock);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      if (!busy) break;
    end
  endtask

  task automatic test_reset();
    @(negedge clock);
    checks++;
    if ({ras, cas, we, addr, bank, dq_out, dq_oe, ldqm, udqm, busy} !==
        {C_NOP, 12'h000, 2'b00, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_held: cmd=%b addr=%h bank=%0d dq=%h oe=%b lm=%b um=%b busy=%b, required 111/0/0/0/0/1/1/0",
               {ras, cas, we}, addr, bank, dq_out, dq_oe, ldqm, udqm, busy);
    end
    reset_n = 1'b1;
    @(negedge clock);
    checks++;
    if (wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: wr_ready=%b, required 1", wr_ready);
    end
    checks++;
    if (({ras, cas, we} !== C_NOP) || (busy !== 1'b0)) begin
      errors++;
      $display("FAIL reset_idle: cmd=%b busy=%b, required 111 busy 0", {ras, cas, we}, busy);
    end
  endtask

  task automatic test_single();
    int    e0;
    logic  exp_b;
    string d;
    log_q.delete();
    words_q.delete();
    grant = 1'b1;
    push_word(22'h012345, 16'hF800, 2'b11);
    e0 = cyc;
    model_expect(e0 + 1);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock);
      exp_b = (k <= 9);
      checks++;
      if (busy !== exp_b) begin
        errors++;
        $display("FAIL single_busy: edge E%0d busy=%b, required %b", k, busy, exp_b);
      end
    end
    wait_events(40);
    d = diff_log();
    checks++;
    if (d != "") begin
      errors++;
      $display("FAIL single_cmds: %s", d);
    end
    grant = 1'b0;
  endtask

  task automatic test_full_row();
    logic [13:0] tag;
    int          t0;
    logic        exp_r;
    string       d;
    log_q.delete();
    words_q.delete();
    grant = 1'b0;
    tag   = 14'($urandom);
    for (int c = 0; c < DEPTH; c++)
      push_word({tag, 8'(c)}, 16'($urandom), 2'($urandom_range(0, 3)));
    checks++;
    if (wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_ready: wr_ready=%b after %0d pushes, required 0", wr_ready, DEPTH);
    end
    // A word offered while full must be refused
    wr_valid = 1'b1;
    address  = {tag, 8'hEE};
    repeat (2) @(negedge clock);
    wr_valid = 1'b0;
    checks++;
    if (wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_hold: wr_ready=%b while full, required 0", wr_ready);
    end
    grant = 1'b1;
    t0    = cyc + 1;
    model_expect(t0);
    for (int k = 0; k <= TRCD; k++) begin
      @(negedge clock);
      exp_r = (cyc >= t0 + TRCD);
      checks++;
      if (wr_ready !== exp_r) begin
        errors++;
        $display("FAIL full_until_pop: edge %0d wr_ready=%b, required %b", cyc - t0, wr_ready, exp_r);
      end
    end
    wait_events(80);
    d = diff_log();
    checks++;
    if (d != "") begin
      errors++;
      $display("FAIL full_row_cmds: %s", d);
    end
    grant = 1'b0;
  endtask

  task automatic test_two_rows();
    int    t0;
    int    first_w;
    int    second_act;
    int    acts;
    string d;
    log_q.delete();
    words_q.delete();
    grant = 1'b0;
    for (int k = 0; k < 3; k++) push_word({2'b01, 12'h010, 8'(k * 7)}, 16'($urandom), 2'b11);
    for (int k = 0; k < 2; k++) push_word({2'b01, 12'h011, 8'(k + 1)}, 16'($urandom), 2'b11);
    grant = 1'b1;
    t0    = cyc + 1;
    model_expect(t0);
    wait_events(80);
    d = diff_log();
    checks++;
    if (d != "") begin
      errors++;
      $display("FAIL two_rows_cmds: %s", d);
    end
    first_w    = -1;
    second_act = -1;
    acts       = 0;
    foreach (log_q[k]) begin
      if (log_q[k].cmd == C_WR && first_w < 0) first_w = log_q[k].t;
      if (log_q[k].cmd == C_ACT) begin
        acts++;
        if (acts == 2) second_act = log_q[k].t;
      end
    end
    checks++;
    if (first_w < 0 || second_act < 0 || (second_act - first_w) < (2 + TWR + TRP + 1)) begin
      errors++;
      $display("FAIL two_rows_gap: first WRITE %0d second ACT %0d, required gap >= %0d",
               first_w, second_act, 2 + TWR + TRP + 1);
    end
    grant = 1'b0;
  endtask

  task automatic test_grant_drop();
    word_t all_q[$];
    int    t0;
    string d;
    log_q.delete();
    words_q.delete();
    grant = 1'b0;
    for (int k = 0; k < 8; k++) push_word({2'b10, 12'h2A5, 8'(k)}, 16'($urandom), 2'($urandom));
    all_q   = words_q;
    words_q = all_q[0:2];
    grant   = 1'b1;
    t0      = cyc + 1;
    model_expect(t0);
    // Drop grant once the second WRITE is on the pins
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (cyc == t0 + TRCD + 1) break;
    end
    grant = 1'b0;
    wait_events(40);
    d = diff_log();
    checks++;
    if (d != "") begin
      errors++;
      $display("FAIL grant_drop_cmds: %s", d);
    end
    wait_idle();
    log_q.delete();
    repeat (10) @(negedge clock);
    checks++;
    if (log_q.size() != 0) begin
      errors++;
      $display("FAIL grant_drop_hold: %0d commands without grant, required 0", log_q.size());
    end
    words_q = all_q[3:7];
    grant   = 1'b1;
    t0      = cyc + 1;
    model_expect(t0);
    wait_events(60);
    d = diff_log();
    checks++;
    if (d != "") begin
      errors++;
      $display("FAIL grant_resume_cmds: %s", d);
    end
    grant = 1'b0;
  endtask

  task automatic test_byte_enable();
    int seen;
    log_q.delete();
    words_q.delete();
    grant = 1'b1;
    seen  = 0;
    push_word({2'b11, 12'h0F0, 8'h3C}, 16'h07E0, 2'b01);
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      checks++;
      if ({ras, cas, we} == C_WR) begin
        seen++;
        if ({ldqm, udqm, dq_oe} !== 3'b011) begin
          errors++;
          $display("FAIL be_write_masks: lm=%b um=%b oe=%b, required 0 1 1", ldqm, udqm, dq_oe);
        end
      end else begin
        if ({ldqm, udqm} !== 2'b11) begin
          errors++;
          $display("FAIL be_idle_masks: lm=%b um=%b, required 1 1", ldqm, udqm);
        end
      end
    end
    checks++;
    if (seen != 1) begin
      errors++;
      $display("FAIL be_write_count: %0d WRITEs, required 1", seen);
    end
    wait_idle();
    grant = 1'b0;
  endtask

  task automatic test_reset_mid();
    log_q.delete();
    words_q.delete();
    grant = 1'b1;
    push_word({2'b00, 12'h055, 8'h10}, 16'hABCD, 2'b11);
    repeat (2) @(negedge clock);
    reset_n = 1'b0;
    #1;
    checks++;
    if (({ras, cas, we} !== C_NOP) || (busy !== 1'b0) || (dq_oe !== 1'b0) ||
        (wr_ready !== 1'b1) || ({ldqm, udqm} !== 2'b11) || (addr !== 12'h000)) begin
      errors++;
      $display("FAIL reset_mid: cmd=%b busy=%b oe=%b ready=%b lm=%b um=%b addr=%h, required 111 0 0 1 1 1 000",
               {ras, cas, we}, busy, dq_oe, wr_ready, ldqm, udqm, addr);
    end
    @(negedge clock);
    reset_n = 1'b1;
    log_q.delete();
    repeat (15) @(negedge clock);
    checks++;
    if (log_q.size() != 0 || busy !== 1'b0 || wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_flush: %0d commands busy=%b ready=%b, required 0 0 1",
               log_q.size(), busy, wr_ready);
    end
    grant = 1'b0;
  endtask

  task automatic test_random();
    logic [13:0] tags [3];
    int          n;
    int          cur;
    int          t0;
    string       d;
    for (int it = 0; it < 6; it++) begin
      log_q.delete();
      words_q.delete();
      grant = 1'b0;
      for (int k = 0; k < 3; k++) tags[k] = 14'($urandom);
      n   = $urandom_range(1, DEPTH);
      cur = $urandom_range(0, 2);
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 3) == 0) cur = $urandom_range(0, 2);
        push_word({tags[cur], 8'($urandom)}, 16'($urandom), 2'($urandom));
      end
      grant = 1'b1;
      t0    = cyc + 1;
      model_expect(t0);
      wait_events(500);
      d = diff_log();
      checks++;
      if (d != "") begin
        errors++;
        $display("FAIL random_%0d_cmds: %s", it, d);
      end
      grant = 1'b0;
      wait_idle();
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    grant      = 1'b0;
    wr_valid   = 1'b0;
    address    = 22'h000000;
    data_write = 16'h0000;
    data_be    = 2'b00;
    repeat (3) @(negedge clock);
    test_reset();
    test_single();
    test_full_row();
    test_two_rows();
    test_grant_drop();
    test_byte_enable();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule
